prio_encoder_rr: RTL
====================

Name: prio_encoder_rr

Overview:
- Parametrised N-input request encoder. It is the registered successor to the team's combinational one-hot 8-to-3 encoder.
- Incoming request pulses are latched into a pending vector. Winners are selected by fixed or round-robin priority. The winner's binary index is presented on a valid/ready output register.
- Used as the interrupt/event index source ahead of downstream handlers, which may stall.

Parameters:
- N, 8, number of request inputs (2..64, need not be a power of 2).
- W, $clog2(N), index width (derived; not overridden).
- RR_EN, 0, 0 = fixed priority (highest index wins); 1 = round-robin.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  request enable; when low, req_in is ignored.
- clr  input  1  synchronous clear of pending vector.
- req_in  input  N  request pulses, bit i = source i.
- out_ready  input  1  downstream accepts out_idx.
- out_valid  output  1  out_idx/out_multi valid.
- out_idx  output  W  binary index of granted source.
- out_multi  output  1  at grant time, more than one source was pending.
- pending  output  N  registered pending vector (status).

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): pending=0, out_valid=0, out_idx=0, out_multi=0, RR pointer=0. The first edge after rst_n rises behaves as a normal cycle.
- Pending update each edge, evaluated in this order:
  - If clr=1: pending <= 0. Same-cycle req_in is dropped; clr wins.
  - Else: pending <= (pending & ~gnt_mask) | (en ? req_in : 0).
  - gnt_mask is the one-hot of the index loaded into the output register this cycle, else 0.
  - A req_in bit equal to the bit being granted re-sets it, so a new request is never lost.
- Load condition: load = (pending != 0) && !clr && (!out_valid || out_ready).
  - Selection uses the registered pending only; same-cycle req_in is not considered.
- On load:
  - out_valid <= 1.
  - out_idx <= winner.
  - out_multi <= (popcount(pending) >= 2).
- No load:
  - out_valid && out_ready: out_valid <= 0; out_idx and out_multi hold their last value.
  - out_valid && !out_ready: out_valid, out_idx and out_multi held stable (no change while stalled).
- clr does not affect a valid output already held; it completes normally.
- Latency: req_in at edge t, pending at t+1, out_valid at t+2 (with output slot free).
- Throughput: one grant per cycle with out_ready held high.
- Fixed priority (RR_EN=0): winner = highest set index of pending. The RR pointer is unused.
- Round-robin (RR_EN=1):
  - Search starts at the pointer p and scans p, p+1, ..., N-1, 0, ..., p-1.
  - The first set bit wins.
  - On load, p <= winner+1, wrapping to 0 when winner = N-1; this includes non-power-of-2 N.
  - p is not advanced when there is no load.
- en low: new requests are masked, but pending continues draining to the output.
- All arithmetic is on W-bit index values. No index ≥ N is ever output.

Test Plan:
- Reset mid-stall: N=8, pending=8'h0C, out_valid=1, out_ready=0. Assert rst_n=0 between edges -> out_valid, out_idx, out_multi and pending go to 0 immediately. After release, no output until new requests arrive.
- Fixed priority: RR_EN=0, one-cycle req_in=8'b0010_0100, out_ready=1 -> at t+2 out_idx=5, out_multi=1. At t+3 out_idx=2, out_multi=0. At t+4 out_valid=0, pending=0.
- Backpressure: out_ready=0 for 4 cycles with idx=5 valid -> out_idx=5 stable and out_valid=1 throughout. Extra req_in=8'h01 accumulates in pending (=8'h05). After out_ready=1 the grants are 2 then 0.
- Round-robin fairness: RR_EN=1, req_in=8'hFF held every cycle, out_ready=1 -> out_idx sequence 0,1,2,...,7,0,1. The same stimulus with RR_EN=0 gives 7 every cycle.
- Non-power-of-2 wrap: N=5 (W=3), RR_EN=1, req_in=5'b10001 held -> out_idx alternates 0,4,0,4. out_idx never exceeds 4.
- Masking and clear:
  - en=0 with req_in=8'h80 -> pending stays 0 and no grant.
  - With pending=8'h30, clr=1 and req_in=8'h01 in the same cycle -> pending=0 next edge and the held output still completes.
  - Regrant race: grant of idx 4 while req_in bit 4 is pulsed -> pending bit 4 remains set and idx 4 is granted again.

Source files
------------

// File: rtl/prio_encoder_rr.sv
// -----------------------------------------------------------------------------
// prio_encoder_rr
//
// Registered N-input request encoder. Request pulses are latched into a pending
// vector. One pending source per cycle is granted, chosen by fixed priority
// (highest index wins) or by round-robin. The granted binary index is presented
// on a valid/ready output register that holds steady while downstream stalls.
//
// Parameters
//   N      number of request sources (2..64, any value)
//   RR_EN  0 = fixed priority, 1 = round-robin
//   W      index width, derived from N
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         request enable; req_in ignored while low
//   clr        synchronous clear of the pending vector
//   req_in     request pulses, bit i = source i
//   out_ready  downstream accepts out_idx
//   out_valid  out_idx / out_multi are valid
//   out_idx    binary index of the granted source
//   out_multi  more than one source was pending at grant time
//   pending    registered pending vector
// -----------------------------------------------------------------------------
module prio_encoder_rr #(
    parameter int N     = 8,
    parameter bit RR_EN = 1'b0,
    localparam int W    = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [N-1:0] req_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic         out_multi,
    output logic [N-1:0] pending
);

    logic [N-1:0] pending_q, pending_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic         out_multi_q, out_multi_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic [W-1:0] winner;
    logic         load;
    logic         multi;
    logic [N-1:0] gnt_mask;

    // Highest set index wins; later iterations overwrite earlier ones.
    function automatic logic [W-1:0] fixed_pick(input logic [N-1:0] vec);
        logic [W-1:0] res;
        res = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) res = W'(i);
        end
        return res;
    endfunction

    // Scan ptr, ptr+1, ..., N-1, 0, ..., ptr-1; first set bit wins. The wrap
    // is done against N rather than 2**W so non-power-of-2 N never yields an
    // index >= N.
    function automatic logic [W-1:0] rr_pick(input logic [N-1:0] vec,
                                             input logic [W-1:0] ptr);
        logic [W-1:0] res;
        logic         found;
        int           j;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && vec[j]) begin
                res   = W'(j);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        winner = RR_EN ? rr_pick(pending_q, ptr_q) : fixed_pick(pending_q);
        load   = (pending_q != '0) && !clr && (!out_valid_q || out_ready);
        // Two or more bits set <=> clearing the lowest set bit leaves something.
        multi  = (pending_q & (pending_q - N'(1))) != '0;
    end

    always_comb begin
        gnt_mask = '0;
        if (load) gnt_mask[winner] = 1'b1;

        // A req_in bit landing on the bit being granted is OR-ed back in after
        // the mask, so a fresh request is never swallowed by its own grant.
        if (clr) pending_d = '0;
        else     pending_d = (pending_q & ~gnt_mask) | (en ? req_in : '0);
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_multi_d = out_multi_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = winner;
            out_multi_d = multi;
            ptr_d       = (winner == W'(N - 1)) ? '0 : winner + W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_multi_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_multi_q <= out_multi_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_multi = out_multi_q;
    assign pending   = pending_q;

endmodule
